fht_io_reorder: RTL and testbench

- Streaming front/back-end for the 4-bank FHT RAM, parametrised in sample width, fixed-point width, bank depth and bank count.
- Load mode takes serial ADC samples over a valid/ready handshake, converts them to fixed point and writes them row-major across the banks.
- Unload mode reads the bank RAM in normal or bit-reversed row order and streams words out with backpressure. It also provides a rounded, saturated ADC-width copy of each word.
- Sits between the ADC/host and the FHT RAM write/read ports. It replaces the manual load and bit-reverse reorder done between the FHT and IFHT passes.

---
 rtl/fht_io_pkg.sv | 44 ++++
 rtl/fht_io_sat.sv | 21 ++
 rtl/fht_io_reorder.sv | 158 +++++++++++++++
 tb/tb_fht_io_reorder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_io_pkg.sv
// Shared types and helpers for the FHT RAM load/unload front end.
// The helpers use fixed 32/64-bit containers so that any parameterisation can call them.
package fht_io_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRdAddr,
    StRdWait,
    StEmit,
    StDone
  } fht_io_state_t;

  // Reverses the low w bits of x; the bits above w come back as zero.
  function automatic logic [31:0] f_bit_rev(input logic [31:0] x, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[5'(w - 1 - i)] = x[5'(i)];
    end
    return r;
  endfunction

  // Rounds half toward +inf, drops frac fractional bits, then clamps to a signed adc-bit range.
  function automatic logic signed [31:0] f_round_sat(input logic signed [63:0] d,
                                                     input int unsigned frac,
                                                     input int unsigned adc);
    logic signed [63:0] s;
    logic signed [63:0] q;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = d + (64'sd1 <<< (frac - 1));
    q  = s >>> frac;
    hi = (64'sd1 <<< (adc - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (adc - 1));
    if (q > hi) begin
      q = hi;
    end else if (q < lo) begin
      q = lo;
    end
    return q[31:0];
  endfunction

endpackage

// File: rtl/fht_io_sat.sv
// Combinational round/saturate of a D_BIT fixed-point word to an ADC_WIDTH integer.
module fht_io_sat
  import fht_io_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = 16,
  parameter int unsigned D_BIT     = 22
) (
  input  logic [D_BIT-1:0]     data_i,
  output logic [ADC_WIDTH-1:0] data_sat_o
);

  logic signed [63:0] data_ext;
  logic signed [31:0] sat_full;
  logic               unused_sat_hi;

  assign data_ext      = {{(64 - D_BIT){data_i[D_BIT-1]}}, data_i};
  assign sat_full      = f_round_sat(data_ext, D_BIT - ADC_WIDTH, ADC_WIDTH);
  assign data_sat_o    = sat_full[ADC_WIDTH-1:0];
  assign unused_sat_hi = ^sat_full[31:ADC_WIDTH];

endmodule

// File: rtl/fht_io_reorder.sv
// Streaming loader/unloader for the banked FHT RAM: serial samples in, row-major bank writes;
// normal or bit-reversed row reads out as a backpressured word stream.
module fht_io_reorder
  import fht_io_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = 16,
  parameter int unsigned D_BIT     = 22,
  parameter int unsigned A_BIT     = 8,
  parameter int unsigned BANKS     = 4,
  parameter int unsigned BW        = $clog2(BANKS)
) (
  input  logic                   iCLK,
  input  logic                   iRESET,
  input  logic                   iLOAD,
  input  logic                   iUNLOAD,
  input  logic                   iREV,
  input  logic                   iVALID,
  input  logic [ADC_WIDTH-1:0]   iDATA,
  output logic                   oREADY,
  output logic [BANKS-1:0]       oWE,
  output logic [A_BIT-1:0]       oADDR_WR,
  output logic [D_BIT-1:0]       oDATA_WR,
  output logic [A_BIT-1:0]       oADDR_RD,
  input  logic [BANKS*D_BIT-1:0] iDATA_RD,
  output logic                   oVALID,
  input  logic                   iREADY,
  output logic [D_BIT-1:0]       oDATA,
  output logic [ADC_WIDTH-1:0]   oDATA_SAT,
  output logic [BW-1:0]          oBANK,
  output logic                   oBUSY,
  output logic                   oDONE
);

  fht_io_state_t                 state_q, state_d;
  logic [A_BIT-1:0]              row_q, row_d;
  logic [BW-1:0]                 bank_q, bank_d;
  logic                          rev_q, rev_d;
  logic [BANKS-1:0]              we_q, we_d;
  logic [A_BIT-1:0]              addr_wr_q, addr_wr_d;
  logic [D_BIT-1:0]              data_wr_q, data_wr_d;
  logic [BANKS-1:0][D_BIT-1:0]   buf_q, buf_d;
  logic                          done_q, done_d;

  logic                          row_last;
  logic                          bank_last;
  logic [31:0]                   row_rev_full;
  logic [A_BIT-1:0]              rd_row;
  logic                          unused_row_rev_hi;

  assign row_last          = (row_q == '1);
  assign bank_last         = (bank_q == '1);
  assign row_rev_full      = f_bit_rev(32'(row_q), A_BIT);
  assign rd_row            = rev_q ? row_rev_full[A_BIT-1:0] : row_q;
  assign unused_row_rev_hi = ^row_rev_full[31:A_BIT];

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    bank_d    = bank_q;
    rev_d     = rev_q;
    we_d      = '0;
    addr_wr_d = addr_wr_q;
    data_wr_d = data_wr_q;
    buf_d     = buf_q;
    // DONE is reported the cycle after the DONE state, together with oBUSY falling.
    done_d    = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (iLOAD) begin
          state_d = StLoad;
          row_d   = '0;
          bank_d  = '0;
        end else if (iUNLOAD) begin
          state_d = StRdAddr;
          rev_d   = iREV;
          row_d   = '0;
          bank_d  = '0;
        end
      end
      StLoad: begin
        if (iVALID) begin
          we_d[bank_q] = 1'b1;
          addr_wr_d    = row_q;
          data_wr_d    = {iDATA, {(D_BIT - ADC_WIDTH){1'b0}}};
          bank_d       = bank_q + 1'b1;
          if (bank_last) begin
            row_d = row_q + 1'b1;
            if (row_last) state_d = StDone;
          end
        end
      end
      StRdAddr: state_d = StRdWait;
      StRdWait: begin
        buf_d   = iDATA_RD;
        state_d = StEmit;
      end
      StEmit: begin
        if (iREADY) begin
          bank_d = bank_q + 1'b1;
          if (bank_last) begin
            row_d   = row_q + 1'b1;
            state_d = row_last ? StDone : StRdAddr;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q   <= StIdle;
      row_q     <= '0;
      bank_q    <= '0;
      rev_q     <= 1'b0;
      we_q      <= '0;
      addr_wr_q <= '0;
      data_wr_q <= '0;
      buf_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      bank_q    <= bank_d;
      rev_q     <= rev_d;
      we_q      <= we_d;
      addr_wr_q <= addr_wr_d;
      data_wr_q <= data_wr_d;
      buf_q     <= buf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    oREADY   = (state_q == StLoad);
    oVALID   = (state_q == StEmit);
    oDATA    = oVALID ? buf_q[bank_q] : '0;
    oBANK    = oVALID ? bank_q : '0;
    // Address is held through RD_WAIT so a RAM sampling late in the cycle still sees it.
    oADDR_RD = (state_q == StRdAddr || state_q == StRdWait) ? rd_row : '0;
    oBUSY    = (state_q != StIdle);
    oDONE    = done_q;
    oWE      = we_q;
    oADDR_WR = addr_wr_q;
    oDATA_WR = data_wr_q;
  end

  fht_io_sat #(
    .ADC_WIDTH(ADC_WIDTH),
    .D_BIT    (D_BIT)
  ) u_sat (
    .data_i    (oDATA),
    .data_sat_o(oDATA_SAT)
  );

endmodule

// File: tb/tb_fht_io_reorder.sv
// Scoreboard bench for fht_io_reorder: bank writes and output words are checked by a monitor
// against queues filled by the stimulus; a 1-cycle-latency RAM model closes the loop.
module tb_fht_io_reorder;

  localparam int unsigned ADC_WIDTH = 16;
  localparam int unsigned D_BIT     = 22;
  localparam int unsigned A_BIT     = 3;
  localparam int unsigned BANKS     = 4;
  localparam int unsigned BW        = 2;
  localparam int unsigned NROWS     = 8;
  localparam int unsigned NWORDS    = 32;
  localparam int          Rev3[8]   = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic                   iCLK;
  logic                   iRESET;
  logic                   iLOAD;
  logic                   iUNLOAD;
  logic                   iREV;
  logic                   iVALID;
  logic [ADC_WIDTH-1:0]   iDATA;
  logic                   oREADY;
  logic [BANKS-1:0]       oWE;
  logic [A_BIT-1:0]       oADDR_WR;
  logic [D_BIT-1:0]       oDATA_WR;
  logic [A_BIT-1:0]       oADDR_RD;
  logic [BANKS*D_BIT-1:0] iDATA_RD;
  logic                   oVALID;
  logic                   iREADY;
  logic [D_BIT-1:0]       oDATA;
  logic [ADC_WIDTH-1:0]   oDATA_SAT;
  logic [BW-1:0]          oBANK;
  logic                   oBUSY;
  logic                   oDONE;

  fht_io_reorder #(
    .ADC_WIDTH(ADC_WIDTH),
    .D_BIT    (D_BIT),
    .A_BIT    (A_BIT),
    .BANKS    (BANKS)
  ) dut (
    .iCLK     (iCLK),
    .iRESET   (iRESET),
    .iLOAD    (iLOAD),
    .iUNLOAD  (iUNLOAD),
    .iREV     (iREV),
    .iVALID   (iVALID),
    .iDATA    (iDATA),
    .oREADY   (oREADY),
    .oWE      (oWE),
    .oADDR_WR (oADDR_WR),
    .oDATA_WR (oDATA_WR),
    .oADDR_RD (oADDR_RD),
    .iDATA_RD (iDATA_RD),
    .oVALID   (oVALID),
    .iREADY   (iREADY),
    .oDATA    (oDATA),
    .oDATA_SAT(oDATA_SAT),
    .oBANK    (oBANK),
    .oBUSY    (oBUSY),
    .oDONE    (oDONE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [BANKS-1:0] we;
    logic [A_BIT-1:0] addr;
    logic [D_BIT-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [D_BIT-1:0]     data;
    logic [BW-1:0]        bank;
    logic [ADC_WIDTH-1:0] sat;
  } out_t;

  wr_t  wq[$];
  out_t oq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_wr = 0;
  int   wr_cyc[128];

  // Bench's own view of RAM contents and the hand-derived saturated value of each word.
  logic [D_BIT-1:0]     mdl_data[BANKS][NROWS];
  logic [ADC_WIDTH-1:0] mdl_sat[BANKS][NROWS];

  // RAM model: synchronous write, registered read, plus a backdoor write port.
  logic [D_BIT-1:0]            ram[BANKS][NROWS];
  logic [BANKS-1:0][D_BIT-1:0] rd_q;
  logic                        bd_we;
  logic [BW-1:0]               bd_bank;
  logic [A_BIT-1:0]            bd_row;
  logic [D_BIT-1:0]            bd_data;

  always @(posedge iCLK) begin
    for (int b = 0; b < BANKS; b++) begin
      if (oWE[b]) ram[b][oADDR_WR] <= oDATA_WR;
      rd_q[b] <= ram[b][oADDR_RD];
    end
    if (bd_we) ram[bd_bank][bd_row] <= bd_data;
  end
  assign iDATA_RD = rd_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge iCLK) begin : monitor
    wr_t  we_exp;
    out_t o_exp;
    cyc++;
    if (iRESET && oWE != '0) begin
      if (n_wr < 128) wr_cyc[n_wr] = cyc;
      n_wr++;
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got we=%b addr=%0d data=0x%0h, expected none",
                 oWE, oADDR_WR, oDATA_WR);
      end else begin
        we_exp = wq.pop_front();
        chk("wr_we", 64'(oWE), 64'(we_exp.we));
        chk("wr_addr", 64'(oADDR_WR), 64'(we_exp.addr));
        chk("wr_data", 64'(oDATA_WR), 64'(we_exp.data));
      end
    end
    if (iRESET && oVALID && iREADY) begin
      if (oq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got data=0x%0h bank=%0d, expected none", oDATA, oBANK);
      end else begin
        o_exp = oq.pop_front();
        chk("out_data", 64'(oDATA), 64'(o_exp.data));
        chk("out_bank", 64'(oBANK), 64'(o_exp.bank));
        chk("out_sat", 64'(oDATA_SAT), 64'(o_exp.sat));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 64'(oWE), 64'd0);
    chk({tag, "_addr_wr"}, 64'(oADDR_WR), 64'd0);
    chk({tag, "_data_wr"}, 64'(oDATA_WR), 64'd0);
    chk({tag, "_addr_rd"}, 64'(oADDR_RD), 64'd0);
    chk({tag, "_valid"}, 64'(oVALID), 64'd0);
    chk({tag, "_data"}, 64'(oDATA), 64'd0);
    chk({tag, "_sat"}, 64'(oDATA_SAT), 64'd0);
    chk({tag, "_bank"}, 64'(oBANK), 64'd0);
    chk({tag, "_busy"}, 64'(oBUSY), 64'd0);
    chk({tag, "_done"}, 64'(oDONE), 64'd0);
    chk({tag, "_ready"}, 64'(oREADY), 64'd0);
  endtask

  task automatic do_load(input bit gapped);
    int  k;
    int  n0;
    bit  pol;
    wr_t w;
    n0  = n_wr;
    k   = 0;
    pol = 1'b0;
    iLOAD = 1'b1;
    @(posedge iCLK); #1;
    iLOAD = 1'b0;
    chk("load_ready", 64'(oREADY), 64'd1);
    chk("load_busy", 64'(oBUSY), 64'd1);
    for (int c = 0; c < 200 && k < NWORDS; c++) begin
      iVALID = gapped ? !pol : 1'b1;
      pol    = !pol;
      iLOAD  = gapped && (k == 11);
      iDATA  = 16'(k);
      if (iVALID && oREADY) begin
        w.we   = 4'(1 << (k % 4));
        w.addr = 3'(k / 4);
        w.data = 22'(k << 6);
        wq.push_back(w);
        k++;
      end
      @(posedge iCLK); #1;
    end
    iVALID = 1'b0;
    iLOAD  = 1'b0;
    chk("load_accepted", 64'(k), 64'(NWORDS));
    chk("load_ready_drop", 64'(oREADY), 64'd0);
    chk("load_done_early", 64'(oDONE), 64'd0);
    @(posedge iCLK); #1;
    chk("load_done", 64'(oDONE), 64'd1);
    chk("load_busy_fall", 64'(oBUSY), 64'd0);
    chk("load_writes", 64'(n_wr - n0), 64'(NWORDS));
    chk("load_span", 64'(wr_cyc[n0 + 31] - wr_cyc[n0]), gapped ? 64'd62 : 64'd31);
    chk("load_wq_empty", 64'(wq.size()), 64'd0);
    @(posedge iCLK); #1;
    chk("load_done_pulse", 64'(oDONE), 64'd0);
  endtask

  // stop_after >= 0 abandons the unload after that many transfers (used for the reset test).
  task automatic do_unload(input bit rev, input bit bp, input int exp_busy, input int stop_after);
    int   r;
    int   xf;
    int   busy;
    int   stall;
    bit   done;
    out_t o;
    logic [D_BIT-1:0] hold_data;
    logic [BW-1:0]    hold_bank;
    for (int i = 0; i < NROWS; i++) begin
      r = rev ? Rev3[i] : i;
      for (int b = 0; b < BANKS; b++) begin
        o.data = mdl_data[b][r];
        o.bank = 2'(b);
        o.sat  = mdl_sat[b][r];
        oq.push_back(o);
      end
    end
    xf = 0; busy = 0; stall = 0; done = 1'b0;
    hold_data = '0; hold_bank = '0;
    iREV    = rev;
    iUNLOAD = 1'b1;
    @(posedge iCLK); #1;
    iUNLOAD = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (oDONE) begin
        done = 1'b1;
        break;
      end
      if (stop_after >= 0 && xf >= stop_after) break;
      if (oBUSY) busy++;
      if (bp && xf == 2 && oVALID) begin
        if (stall == 0) begin
          hold_data = oDATA;
          hold_bank = oBANK;
        end else begin
          chk("bp_hold_data", 64'(oDATA), 64'(hold_data));
          chk("bp_hold_bank", 64'(oBANK), 64'(hold_bank));
        end
        iREADY = (stall >= 5);
        stall++;
      end else begin
        iREADY = 1'b1;
      end
      if (oVALID && iREADY) xf++;
      @(posedge iCLK); #1;
    end
    iREADY = 1'b1;
    if (stop_after < 0) begin
      chk("unload_done", 64'(done), 64'd1);
      chk("unload_words", 64'(xf), 64'(NWORDS));
      chk("unload_busy_cycles", 64'(busy), 64'(exp_busy));
      chk("unload_oq_empty", 64'(oq.size()), 64'd0);
      chk("unload_idle", 64'(oBUSY), 64'd0);
    end
  endtask

  task automatic bd_write(input int b, input int r, input logic [D_BIT-1:0] d,
                          input logic [ADC_WIDTH-1:0] s);
    bd_we   = 1'b1;
    bd_bank = 2'(b);
    bd_row  = 3'(r);
    bd_data = d;
    @(posedge iCLK); #1;
    bd_we = 1'b0;
    mdl_data[b][r] = d;
    mdl_sat[b][r]  = s;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    iRESET = 1'b1; iLOAD = 1'b0; iUNLOAD = 1'b0; iREV = 1'b0;
    iVALID = 1'b0; iDATA = '0; iREADY = 1'b1;
    bd_we = 1'b0; bd_bank = '0; bd_row = '0; bd_data = '0;
    for (int r = 0; r < NROWS; r++) begin
      for (int b = 0; b < BANKS; b++) begin
        mdl_data[b][r] = 22'((4 * r + b) << 6);
        mdl_sat[b][r]  = 16'(4 * r + b);
      end
    end
    #2 iRESET = 1'b0;
    #1 chk_all_zero("rst");
    repeat (3) @(posedge iCLK);
    #1 iRESET = 1'b1;
    @(posedge iCLK); #1;
    chk_all_zero("idle");

    do_load(1'b0);
    do_load(1'b1);
    do_unload(1'b1, 1'b0, 49, -1);
    do_unload(1'b0, 1'b1, 54, -1);

    // 1.5 rounds up, -1.5 rounds to -1, extremes clamp, 0.484 rounds to 0.
    bd_write(0, 0, 22'h1FFFFF, 16'h7FFF);
    bd_write(1, 0, 22'd96,     16'd2);
    bd_write(2, 0, 22'h3FFFA0, 16'hFFFF);
    bd_write(3, 0, 22'h200000, 16'h8000);
    bd_write(0, 1, 22'd31,     16'd0);
    do_unload(1'b0, 1'b0, 49, -1);
    for (int b = 0; b < BANKS; b++) bd_write(b, 0, 22'(b << 6), 16'(b));
    bd_write(0, 1, 22'(4 << 6), 16'd4);

    do_unload(1'b0, 1'b0, 0, 6);
    chk("mid_emit_valid", 64'(oVALID), 64'd1);
    #2 iRESET = 1'b0;
    #1 chk_all_zero("rst_emit");
    oq.delete();
    repeat (2) @(posedge iCLK);
    #3 iRESET = 1'b1;
    @(posedge iCLK); #1;
    chk("post_rst_busy", 64'(oBUSY), 64'd0);
    chk("post_rst_valid", 64'(oVALID), 64'd0);
    do_unload(1'b0, 1'b0, 49, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
